// File: rtl/bank_read_pkg.sv
// Shared constants and helpers for the bank read controller.
// Optional feature macro: RDCTRL_OOR_EN (out-of-range address reporting).
package bank_read_pkg;

    // Default number of write agents (banks) for the multi-bank RAM.
    localparam int NB_WRAGENT_DFLT = 2;

    // Width of a bank index for a given number of banks (never zero).
    function automatic int sel_width(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

    // Bank index width for the default configuration.
    localparam int SEL_W = (NB_WRAGENT_DFLT > 1) ? $clog2(NB_WRAGENT_DFLT) : 1;

    // Output buffer depth and the width of its occupancy counter.
    localparam int FIFO_DEPTH = 3;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    // Responses already buffered plus the one (at most) still coming back from the banks.
    function automatic logic [CNT_W:0] fill_level(input logic [CNT_W-1:0] count,
                                                  input logic             inflight);
        return {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    endfunction

endpackage

// File: rtl/bank_read_fifo.sv
// 3-entry synchronous FIFO holding read responses until downstream takes them.
// Pointers wrap modulo FIFO_DEPTH; push into a full FIFO is dropped unless a pop
// happens in the same cycle, pop from an empty FIFO is ignored.
module bank_read_fifo
    import bank_read_pkg::*;
#(
    parameter int WIDTH = 64
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [CNT_W-1:0] next_ptr(input logic [CNT_W-1:0] p);
        return (p == CNT_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; reset clears the contents so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bank_read_ctrl.sv
// Read-side controller for the multi-bank RAM.
// A request is broadcast to every bank and to the live-value table; one cycle later
// the LVT index picks the bank holding the live word, which is buffered in a
// 3-entry FIFO. req_ready reserves FIFO space for the read still in flight, so
// backpressure never drops bank data.
// Handshakes: a transfer happens on a cycle where valid & ready are both high;
// valid never waits on ready, and req_ready depends only on registered state.
// Optional feature macro: RDCTRL_OOR_EN adds rsp_err and suppresses bank access
// for addresses >= RAM_DEPTH.
module bank_read_ctrl
    import bank_read_pkg::*;
#(
    parameter  int NB_WRAGENT = NB_WRAGENT_DFLT,
    parameter  int ADDR_WIDTH = 9,
    parameter  int RAM_DEPTH  = 2**ADDR_WIDTH,
    parameter  int DATA_WIDTH = 64,
    localparam int SEL_BITS   = sel_width(NB_WRAGENT)
)(
    input  logic                             rdclk,
    input  logic                             rdrst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic [NB_WRAGENT-1:0]            bank_rden,
    output logic [ADDR_WIDTH*NB_WRAGENT-1:0] bank_rdaddr,
    input  logic [DATA_WIDTH*NB_WRAGENT-1:0] bank_rddata,
    output logic                             lvt_rden,
    output logic [ADDR_WIDTH-1:0]            lvt_rdaddr,
    input  logic [SEL_BITS-1:0]              lvt_rddata
`ifdef RDCTRL_OOR_EN
    ,
    output logic                             rsp_err
`endif
);

`ifdef RDCTRL_OOR_EN
    localparam int FW = DATA_WIDTH + 1;
`else
    localparam int FW = DATA_WIDTH;
`endif

    logic                  accept;
    logic                  fwd;
    logic                  addr_ok;
    logic                  inflight;
    logic                  inflight_err;
    logic [CNT_W-1:0]      count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [FW-1:0]         push_word;
    logic [FW-1:0]         head_word;

`ifdef RDCTRL_OOR_EN
    assign addr_ok = (32'(req_addr) < 32'(RAM_DEPTH));
`else
    assign addr_ok = 1'b1;
`endif

    // Space is reserved for the in-flight read; held low while reset is asserted.
    assign req_ready = rdrst_n & ~fifo_full &
                       (fill_level(count, inflight) < (CNT_W+1)'(FIFO_DEPTH));
    assign accept    = req_valid & req_ready;
    assign fwd       = accept & addr_ok;

    assign bank_rden   = {NB_WRAGENT{fwd}};
    assign lvt_rden    = fwd;
    assign bank_rdaddr = {NB_WRAGENT{req_addr}};
    assign lvt_rdaddr  = req_addr;

    // One read is in flight for exactly the cycle after it is accepted.
    always_ff @(posedge rdclk or negedge rdrst_n) begin
        if (!rdrst_n) begin
            inflight     <= 1'b0;
            inflight_err <= 1'b0;
        end else begin
            inflight     <= accept;
            inflight_err <= accept & ~addr_ok;
        end
    end

    // Pick the bank named by the LVT; an index past the last bank falls back to bank 0.
    always_comb begin
        sel_data = bank_rddata[DATA_WIDTH-1:0];
        for (int i = 0; i < NB_WRAGENT; i++) begin
            if (32'(lvt_rddata) == 32'(i)) begin
                sel_data = bank_rddata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef RDCTRL_OOR_EN
    assign push_word = {inflight_err, inflight_err ? {DATA_WIDTH{1'b0}} : sel_data};
    assign rsp_err   = head_word[DATA_WIDTH];
`else
    assign push_word = sel_data;
`endif

    assign rsp_valid = ~fifo_empty;
    assign rsp_data  = head_word[DATA_WIDTH-1:0];

    bank_read_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .clk   (rdclk),
        .rst_n (rdrst_n),
        .push  (inflight),
        .pop   (rsp_ready),
        .din   (push_word),
        .dout  (head_word),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_bank_read_ctrl.sv
// Directed bench for bank_read_ctrl: bank and LVT models with 1-cycle latency,
// one task per scenario, inputs driven and outputs sampled around the falling edge.
`timescale 1ns/1ps
module tb_bank_read_ctrl;

    localparam int NB    = 2;
    localparam int AW    = 9;
    localparam int DW    = 64;
    localparam int DEPTH = 300;
    localparam int MEMSZ = 2**AW;

    logic             rdclk = 1'b0;
    logic             rdrst_n;
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_addr;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DW-1:0]    rsp_data;
    logic [NB-1:0]    bank_rden;
    logic [AW*NB-1:0] bank_rdaddr;
    logic [DW*NB-1:0] bank_rddata = '0;
    logic             lvt_rden;
    logic [AW-1:0]    lvt_rdaddr;
    logic [0:0]       lvt_rddata = '0;
`ifdef RDCTRL_OOR_EN
    logic             rsp_err;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] bank_mem [NB][MEMSZ];
    logic          lvt_mem  [MEMSZ];
    logic [DW-1:0] exp_q [$];

    always #5 rdclk = ~rdclk;

    bank_read_ctrl #(
        .NB_WRAGENT (NB),
        .ADDR_WIDTH (AW),
        .RAM_DEPTH  (DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .rdclk       (rdclk),
        .rdrst_n     (rdrst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .bank_rden   (bank_rden),
        .bank_rdaddr (bank_rdaddr),
        .bank_rddata (bank_rddata),
        .lvt_rden    (lvt_rden),
        .lvt_rdaddr  (lvt_rdaddr),
        .lvt_rddata  (lvt_rddata)
`ifdef RDCTRL_OOR_EN
        ,
        .rsp_err     (rsp_err)
`endif
    );

    // Bank and LVT memories: registered read, one cycle after the enable.
    always @(posedge rdclk) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_rden[b]) begin
                bank_rddata[b*DW +: DW] <= bank_mem[b][bank_rdaddr[b*AW +: AW]];
            end
        end
        if (lvt_rden) begin
            lvt_rddata <= lvt_mem[lvt_rdaddr];
        end
    end

    function automatic logic [DW-1:0] exp_val(input int a);
        return lvt_mem[a] ? bank_mem[1][a] : bank_mem[0][a];
    endfunction

    task automatic init_mem();
        for (int a = 0; a < MEMSZ; a++) begin
            bank_mem[0][a] = 64'h0A00_0000_0000_0000 + 64'(a) * 64'h101;
            bank_mem[1][a] = 64'h0B00_0000_0000_0000 + 64'(a) * 64'h10001;
            lvt_mem[a]     = ((a & 1) ^ ((a >> 1) & 1)) != 0;
        end
        bank_mem[0][5] = 64'hA0;
        bank_mem[1][5] = 64'hB1;
        lvt_mem[5]     = 1'b1;
    endtask

    task automatic test_reset();
        rdrst_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge rdclk);
        #1;
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_req_ready: got %b expected 0", req_ready);
        end
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_rsp: got valid=%b data=%h expected 0/0", rsp_valid, rsp_data);
        end
        tests_run++;
        if (bank_rden !== '0 || lvt_rden !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rden: got bank=%b lvt=%b expected 0/0", bank_rden, lvt_rden);
        end
        @(negedge rdclk);
        rdrst_n = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_req_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_single_read();
        logic [AW*NB-1:0] exp_addr;
        exp_addr = {NB{9'd5}};
        @(negedge rdclk);
        req_valid = 1'b1;
        req_addr  = 9'd5;
        rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || bank_rden !== 2'b11 || lvt_rden !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_issue: got ready=%b bank_rden=%b lvt_rden=%b expected 1/11/1",
                     req_ready, bank_rden, lvt_rden);
        end
        tests_run++;
        if (bank_rdaddr !== exp_addr || lvt_rdaddr !== 9'd5) begin
            tests_failed++;
            $display("FAIL single_addr: got bank=%h lvt=%h expected %h/005",
                     bank_rdaddr, lvt_rdaddr, exp_addr);
        end
        @(negedge rdclk);
        req_valid = 1'b0;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || bank_rden !== 2'b00) begin
            tests_failed++;
            $display("FAIL single_t1: got rsp_valid=%b bank_rden=%b expected 0/00", rsp_valid, bank_rden);
        end
        @(negedge rdclk);
        #1;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== 64'hB1) begin
            tests_failed++;
            $display("FAIL single_rsp: got valid=%b data=%h expected 1/%h", rsp_valid, rsp_data, 64'hB1);
        end
        @(negedge rdclk);
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_drain: got rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d;
        exp_q.delete();
        for (int c = 0; c < 18; c++) begin
            @(negedge rdclk);
            rsp_ready = 1'b1;
            if (c < 16) begin
                req_valid = 1'b1;
                req_addr  = AW'(40 + 3 * c);
                exp_q.push_back(exp_val(40 + 3 * c));
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (c < 16) begin
                tests_run++;
                if (req_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stream_ready c=%0d: got %b expected 1", c, req_ready);
                end
            end
            if (c >= 2) begin
                exp_d = exp_q.pop_front();
                tests_run++;
                if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
                    tests_failed++;
                    $display("FAIL stream_rsp c=%0d: got valid=%b data=%h expected 1/%h",
                             c, rsp_valid, rsp_data, exp_d);
                end
            end else begin
                tests_run++;
                if (rsp_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stream_lead c=%0d: got rsp_valid=%b expected 0", c, rsp_valid);
                end
            end
        end
        @(negedge rdclk);
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL stream_tail: got rsp_valid=%b left=%0d expected 0/0", rsp_valid, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int accepts;
        accepts = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge rdclk);
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            req_addr  = AW'(100 + accepts);
            #1;
            if (req_ready === 1'b1) accepts++;
        end
        @(negedge rdclk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (accepts != 3) begin
            tests_failed++;
            $display("FAIL bp_accepts: got %0d expected 3", accepts);
        end
        tests_run++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== exp_val(100)) begin
            tests_failed++;
            $display("FAIL bp_head: got ready=%b valid=%b data=%h expected 0/1/%h",
                     req_ready, rsp_valid, rsp_data, exp_val(100));
        end
        @(negedge rdclk);
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== exp_val(101)) begin
            tests_failed++;
            $display("FAIL bp_second: got ready=%b valid=%b data=%h expected 1/1/%h",
                     req_ready, rsp_valid, rsp_data, exp_val(101));
        end
        @(negedge rdclk);
        #1;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_val(102)) begin
            tests_failed++;
            $display("FAIL bp_third: got valid=%b data=%h expected 1/%h", rsp_valid, rsp_data, exp_val(102));
        end
        @(negedge rdclk);
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_empty: got valid=%b ready=%b expected 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_push_pop();
        for (int c = 0; c < 3; c++) begin
            @(negedge rdclk);
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            req_addr  = AW'(200 + c);
        end
        // two buffered, one in flight: pop and push land on the same edge
        @(negedge rdclk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== exp_val(200)) begin
            tests_failed++;
            $display("FAIL pp_full: got ready=%b valid=%b data=%h expected 0/1/%h",
                     req_ready, rsp_valid, rsp_data, exp_val(200));
        end
        @(negedge rdclk);
        rsp_ready = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || rsp_data !== exp_val(201)) begin
            tests_failed++;
            $display("FAIL pp_next: got ready=%b data=%h expected 1/%h", req_ready, rsp_data, exp_val(201));
        end
        @(negedge rdclk);
        rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_val(201)) begin
            tests_failed++;
            $display("FAIL pp_hold: got valid=%b data=%h expected 1/%h", rsp_valid, rsp_data, exp_val(201));
        end
        @(negedge rdclk);
        #1;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_val(202)) begin
            tests_failed++;
            $display("FAIL pp_last: got valid=%b data=%h expected 1/%h", rsp_valid, rsp_data, exp_val(202));
        end
        @(negedge rdclk);
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL pp_count: got rsp_valid=%b expected 0 (two entries only)", rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            @(negedge rdclk);
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            req_addr  = AW'(250 + c);
        end
        @(negedge rdclk);
        req_valid = 1'b0;
        rdrst_n   = 1'b0;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0 || req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_assert: got valid=%b data=%h ready=%b expected 0/0/0",
                     rsp_valid, rsp_data, req_ready);
        end
        @(negedge rdclk);
        rdrst_n   = 1'b1;
        rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rmid_ready: got %b expected 1", req_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge rdclk);
            #1;
            tests_run++;
            if (rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL rmid_stale c=%0d: got rsp_valid=%b expected 0", c, rsp_valid);
            end
        end
    endtask

`ifdef RDCTRL_OOR_EN
    task automatic test_out_of_range();
        logic [AW-1:0] addrs [3];
        addrs[0] = 9'd7;
        addrs[1] = 9'd300;
        addrs[2] = 9'd8;
        for (int c = 0; c < 5; c++) begin
            @(negedge rdclk);
            rsp_ready = 1'b1;
            req_valid = (c < 3);
            if (c < 3) req_addr = addrs[c];
            #1;
            if (c == 1) begin
                tests_run++;
                if (req_ready !== 1'b1 || bank_rden !== 2'b00 || lvt_rden !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL oor_issue: got ready=%b bank=%b lvt=%b expected 1/00/0",
                             req_ready, bank_rden, lvt_rden);
                end
            end
            if (c == 2) begin
                tests_run++;
                if (rsp_valid !== 1'b1 || rsp_data !== exp_val(7) || rsp_err !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL oor_before: got v=%b d=%h e=%b expected 1/%h/0",
                             rsp_valid, rsp_data, rsp_err, exp_val(7));
                end
            end
            if (c == 3) begin
                tests_run++;
                if (rsp_valid !== 1'b1 || rsp_data !== '0 || rsp_err !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL oor_rsp: got v=%b d=%h e=%b expected 1/0/1", rsp_valid, rsp_data, rsp_err);
                end
            end
            if (c == 4) begin
                tests_run++;
                if (rsp_valid !== 1'b1 || rsp_data !== exp_val(8) || rsp_err !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL oor_after: got v=%b d=%h e=%b expected 1/%h/0",
                             rsp_valid, rsp_data, rsp_err, exp_val(8));
                end
            end
        end
    endtask
`endif

    initial begin
        init_mem();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
`ifdef RDCTRL_OOR_EN
        test_out_of_range();
`endif
        @(negedge rdclk);
        req_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
